mult_div_unit: RTL and testbench

- Multi-cycle multiply/divide unit in the EX stage of the 5-stage MIPS pipeline.
- Owns the HI/LO registers and executes mult, multu, div, divu, mthi and mtlo.
- Drives Busy to the hazard/stall logic. The same Start pulse also reaches the stall logic as Start_E, so MD-class instructions in D are stalled while an operation runs.
- mfhi/mflo read HI/LO combinationally through the E-stage result mux.

---
 rtl/mult_div_unit.sv | 192 +++++++++++++++++++
 tb/tb_mult_div_unit.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// ---------------------------------------------------------------------------
// mult_div_unit
//
// Purpose:
//   This is the multi-cycle multiply/divide unit for the EX stage of the
//   5-stage MIPS pipeline. It owns the architectural HI/LO registers and
//   executes mult, multu, div, divu, mthi and mtlo.
//
//   The result is computed combinationally when Start is seen and held in
//   tmp_hi/tmp_lo. Busy then stays high for a fixed number of cycles, and
//   HI/LO are updated on the last of those cycles.
//
//   A Start that arrives while the unit is busy is ignored.
//
// Optional feature:
//   When the macro MULT_DIV_MADD_EN is defined, MDOp 110 (madd) and 111
//   (msub) are accepted as signed accumulate operations.
//   When it is undefined, both encodings are NOPs.
//
// Ports:
//   clk    in   1   system clock, rising edge
//   reset  in   1   asynchronous, active-high; clears all state
//   Start  in   1   one-cycle pulse, E-stage MD instruction valid
//   MDOp   in   3   000 mult, 001 multu, 010 div, 011 divu,
//                   100 mthi, 101 mtlo, 110 madd, 111 msub
//   A      in  32   forwarded rs value
//   B      in  32   forwarded rt value
//   Busy   out  1   operation in progress
//   HI     out 32   architectural HI register
//   LO     out 32   architectural LO register
// ---------------------------------------------------------------------------
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [2:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               busy_q, busy_d;
    logic [31:0]        hi_q, hi_d, lo_q, lo_d;
    logic [31:0]        tmp_hi_q, tmp_hi_d, tmp_lo_q, tmp_lo_d;
    // Cleared for divide-by-zero so completion leaves HI/LO untouched.
    logic               wr_q, wr_d;

    logic signed [63:0] a_sx, b_sx, prod_s;
    logic [63:0]        prod_u;
    logic [31:0]        a_mag, b_mag, den_s, den_u;
    logic [31:0]        q_mag, r_mag, q_s, r_s, q_u, r_u;
    logic               div_by0;
    logic               launch;
    logic [63:0]        res;
    logic [CNT_W-1:0]   res_cnt;
    logic               res_wr;
`ifdef MULT_DIV_MADD_EN
    logic [63:0]        acc;
`endif

    // Arithmetic datapath
    always_comb begin
        a_sx   = {{32{A[31]}}, A};
        b_sx   = {{32{B[31]}}, B};
        prod_s = a_sx * b_sx;
        prod_u = {32'd0, A} * {32'd0, B};

        // Signed divide works on magnitudes so that 0x80000000 / -1 wraps
        // cleanly to 0x80000000 instead of hitting an overflow corner.
        div_by0 = (B == 32'd0);
        a_mag   = A[31] ? (32'd0 - A) : A;
        b_mag   = B[31] ? (32'd0 - B) : B;
        den_s   = div_by0 ? 32'd1 : b_mag;
        den_u   = div_by0 ? 32'd1 : B;
        q_mag   = a_mag / den_s;
        r_mag   = a_mag % den_s;
        q_s     = (A[31] ^ B[31]) ? (32'd0 - q_mag) : q_mag;
        r_s     = A[31] ? (32'd0 - r_mag) : r_mag;
        q_u     = A / den_u;
        r_u     = A % den_u;
`ifdef MULT_DIV_MADD_EN
        acc     = {hi_q, lo_q};
`endif
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        busy_d   = busy_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        tmp_hi_d = tmp_hi_q;
        tmp_lo_d = tmp_lo_q;
        wr_d     = wr_q;
        launch   = 1'b0;
        res      = 64'd0;
        res_cnt  = CNT_W'(MULT_CYCLES);
        res_wr   = 1'b1;

        case (state_q)
            IDLE: begin
                if (Start) begin
                    case (MDOp)
                        3'b000: begin launch = 1'b1; res = prod_s; end
                        3'b001: begin launch = 1'b1; res = prod_u; end
                        3'b010: begin
                            launch  = 1'b1;
                            res     = {r_s, q_s};
                            res_cnt = CNT_W'(DIV_CYCLES);
                            res_wr  = ~div_by0;
                        end
                        3'b011: begin
                            launch  = 1'b1;
                            res     = {r_u, q_u};
                            res_cnt = CNT_W'(DIV_CYCLES);
                            res_wr  = ~div_by0;
                        end
                        3'b100: hi_d = A;
                        3'b101: lo_d = A;
`ifdef MULT_DIV_MADD_EN
                        3'b110: begin launch = 1'b1; res = acc + prod_s; end
                        3'b111: begin launch = 1'b1; res = acc - prod_s; end
`endif
                        default: ;
                    endcase
                end
                if (launch) begin
                    tmp_hi_d = res[63:32];
                    tmp_lo_d = res[31:0];
                    wr_d     = res_wr;
                    count_d  = res_cnt;
                    busy_d   = 1'b1;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (count_q == CNT_W'(1)) begin
                    if (wr_q) begin
                        hi_d = tmp_hi_q;
                        lo_d = tmp_lo_q;
                    end
                    count_d = '0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    count_d = count_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            busy_q   <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            tmp_hi_q <= 32'd0;
            tmp_lo_q <= 32'd0;
            wr_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            busy_q   <= busy_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            tmp_hi_q <= tmp_hi_d;
            tmp_lo_q <= tmp_lo_d;
            wr_q     <= wr_d;
        end
    end

    assign Busy = busy_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// ---------------------------------------------------------------------------
// tb_mult_div_unit
//
// This is a directed-vector bench for mult_div_unit.
//
// It drives a table of operations, each with an expected Busy length and
// the HI/LO values that should follow. It then runs hand-written sequences
// for the following cases:
//   - Start ignored while busy
//   - madd/msub
//   - reset in the middle of a run
// ---------------------------------------------------------------------------
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        Start;
    logic [2:0]  MDOp;
    logic [31:0] A, B;
    logic        Busy;
    logic [31:0] HI, LO;

    int compared = 0;
    int mismatched = 0;

    mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .Start (Start),
        .MDOp  (MDOp),
        .A     (A),
        .B     (B),
        .Busy  (Busy),
        .HI    (HI),
        .LO    (LO)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          cycles;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue one Start pulse, then count Busy cycles (bounded).
    // This returns one cycle after Busy drops, which is when the new HI/LO
    // should be visible.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, output int n);
        @(posedge clk); #1;
        Start = 1'b1; MDOp = op; A = a; B = b;
        @(posedge clk); #1;
        Start = 1'b0;
        n = 0;
        while (Busy && n < 64) begin
            n++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int n;
        int n2;

        vecs[0]  = '{"mult_neg1x2",  3'b000, 32'hFFFFFFFF, 32'h00000002, 5,  32'hFFFFFFFF, 32'hFFFFFFFE};
        vecs[1]  = '{"multu_big",    3'b001, 32'hFFFFFFFF, 32'h00000002, 5,  32'h00000001, 32'hFFFFFFFE};
        vecs[2]  = '{"mult_maxpos",  3'b000, 32'h7FFFFFFF, 32'h7FFFFFFF, 5,  32'h3FFFFFFF, 32'h00000001};
        vecs[3]  = '{"mult_negneg",  3'b000, 32'hFFFFFFFD, 32'hFFFFFFFB, 5,  32'h00000000, 32'h0000000F};
        vecs[4]  = '{"div_m7_2",     3'b010, 32'hFFFFFFF9, 32'h00000002, 10, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[5]  = '{"div_ovf",      3'b010, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000};
        vecs[6]  = '{"div_7_m2",     3'b010, 32'h00000007, 32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD};
        vecs[7]  = '{"divu_big",     3'b011, 32'hFFFFFFFF, 32'h00000010, 10, 32'h0000000F, 32'h0FFFFFFF};
        vecs[8]  = '{"mthi",         3'b100, 32'h12345678, 32'h00000000, 0,  32'h12345678, 32'h0FFFFFFF};
        vecs[9]  = '{"mtlo",         3'b101, 32'h9ABCDEF0, 32'h00000000, 0,  32'h12345678, 32'h9ABCDEF0};
        vecs[10] = '{"divu_by0",     3'b011, 32'h00000064, 32'h00000000, 10, 32'h12345678, 32'h9ABCDEF0};
        vecs[11] = '{"div_by0",      3'b010, 32'hFFFFFFF9, 32'h00000000, 10, 32'h12345678, 32'h9ABCDEF0};

        reset = 1'b1; Start = 1'b0; MDOp = 3'b000; A = '0; B = '0;
        #1;
        check("reset_busy", {31'd0, Busy}, 32'd0);
        check("reset_hi", HI, 32'd0);
        check("reset_lo", LO, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, n);
            check({vecs[i].name, "_cycles"}, n, vecs[i].cycles);
            check({vecs[i].name, "_hi"}, HI, vecs[i].hi);
            check({vecs[i].name, "_lo"}, LO, vecs[i].lo);
        end

        // divu 7/2 with a mult 3x4 Start in its 3rd Busy cycle
        @(posedge clk); #1;
        Start = 1'b1; MDOp = 3'b011; A = 32'd7; B = 32'd2;
        @(posedge clk); #1;                 // Busy cycle 1
        Start = 1'b0;
        @(posedge clk); #1;                 // Busy cycle 2
        @(posedge clk); #1;                 // Busy cycle 3
        Start = 1'b1; MDOp = 3'b000; A = 32'd3; B = 32'd4;
        @(posedge clk); #1;                 // Busy cycle 4
        Start = 1'b0;
        n = 3;
        while (Busy && n < 64) begin
            n++;
            @(posedge clk); #1;
        end
        check("ignore_cycles", n, 32'd10);
        check("ignore_hi", HI, 32'd1);
        check("ignore_lo", LO, 32'd3);
        // The ignored mult must not start a run afterwards
        @(posedge clk); #1;
        check("ignore_no_restart", {31'd0, Busy}, 32'd0);
        check("ignore_hi_late", HI, 32'd1);

        // madd / msub
        do_op(3'b100, 32'h00000000, 32'h0, n);
        do_op(3'b101, 32'hFFFFFFFF, 32'h0, n);
        do_op(3'b110, 32'h00000001, 32'h00000001, n);
`ifdef MULT_DIV_MADD_EN
        check("madd_cycles", n, 32'd5);
        check("madd_hi", HI, 32'h00000001);
        check("madd_lo", LO, 32'h00000000);
        do_op(3'b111, 32'h00000002, 32'h00000003, n2);
        check("msub_cycles", n2, 32'd5);
        check("msub_hi", HI, 32'h00000000);
        check("msub_lo", LO, 32'hFFFFFFFA);
`else
        check("madd_nop_cycles", n, 32'd0);
        check("madd_nop_hi", HI, 32'h00000000);
        check("madd_nop_lo", LO, 32'hFFFFFFFF);
        do_op(3'b111, 32'h00000002, 32'h00000003, n2);
        check("msub_nop_cycles", n2, 32'd0);
        check("msub_nop_hi", HI, 32'h00000000);
        check("msub_nop_lo", LO, 32'hFFFFFFFF);
`endif

        // Reset in the 2nd Busy cycle of a mult
        do_op(3'b100, 32'hCAFEF00D, 32'h0, n);
        @(posedge clk); #1;
        Start = 1'b1; MDOp = 3'b000; A = 32'd6; B = 32'd7;
        @(posedge clk); #1;                 // Busy cycle 1
        Start = 1'b0;
        check("pre_reset_busy", {31'd0, Busy}, 32'd1);
        @(posedge clk); #1;                 // Busy cycle 2
        reset = 1'b1;
        #1;
        check("midrun_reset_busy", {31'd0, Busy}, 32'd0);
        check("midrun_reset_hi", HI, 32'd0);
        check("midrun_reset_lo", LO, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("post_reset_busy", {31'd0, Busy}, 32'd0);
        check("post_reset_hi", HI, 32'd0);
        check("post_reset_lo", LO, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
